// File: rtl/mem_access_ctl.sv
// mem_access_ctl: load/store access controller for the CPU data port of a
// big-endian byte-lane memory (lane 3 = bits [31:24] = byte offset 0).
// It accepts one request at a time and walks IDLE -> ISSUE -> (WAIT) -> RESP.
// Optional build macro MISALIGN_TRAP_EN: when defined, misaligned halfword
// and word accesses are reported as errors. When undefined, the low address
// bits are forced to zero and the access proceeds.
module mem_access_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wren,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_legal;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_err;
  logic [31:0] w_addr_eff;
  logic [3:0]  w_wren;
  logic [31:0] w_din;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
`ifdef MISALIGN_TRAP_EN
  logic        w_misaligned;
`endif

  // Classify the incoming request: legality, size, error and effective address
  always_comb begin
    w_legal   = 1'b0;
    w_is_half = 1'b0;
    w_is_word = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_SB: w_legal = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        w_legal   = 1'b1;
        w_is_half = 1'b1;
      end
      OP_LW, OP_SW: begin
        w_legal   = 1'b1;
        w_is_word = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    w_addr_eff = req_addr;
`ifdef MISALIGN_TRAP_EN
    w_misaligned = (w_is_half & req_addr[0]) | (w_is_word & (req_addr[1:0] != 2'b00));
    w_err        = ~w_legal | w_misaligned;
`else
    // Misaligned accesses are silently aligned down to the access size
    w_err = ~w_legal;
    if (w_is_half) w_addr_eff[0] = 1'b0;
    if (w_is_word) w_addr_eff[1:0] = 2'b00;
`endif
  end

  // Store lane enables and replicated store data for the latched request
  always_comb begin
    w_wren = 4'b0000;
    w_din  = 32'd0;
    case (r_op)
      OP_SB: begin
        w_wren = 4'b1000 >> r_addr[1:0];
        w_din  = {4{r_wdata[7:0]}};
      end
      OP_SH: begin
        w_wren = r_addr[1] ? 4'b0011 : 4'b1100;
        w_din  = {2{r_wdata[15:0]}};
      end
      OP_SW: begin
        w_wren = 4'b1111;
        w_din  = r_wdata;
      end
      default: begin
        w_wren = 4'b0000;
        w_din  = 32'd0;
      end
    endcase
  end

  // Pick the addressed byte/half from the returned word and extend it
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = mem_dout[31:24];
      2'd1:    w_byte = mem_dout[23:16];
      2'd2:    w_byte = mem_dout[15:8];
      default: w_byte = mem_dout[7:0];
    endcase
    w_half = r_addr[1] ? mem_dout[15:0] : mem_dout[31:16];
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      OP_LW:   w_load_data = mem_dout;
      default: w_load_data = 32'd0;
    endcase
  end

  // State register; async reset drops any in-flight write immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and output decode; memory strobes only live in ISSUE
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    mem_addr     = 32'd0;
    mem_wren     = 4'b0000;
    mem_din      = 32'd0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = w_err ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem_addr     = {r_addr[31:2], 2'b00};
        mem_wren     = w_wren;
        mem_din      = w_din;
        w_state_next = r_op[3] ? S_RESP : S_WAIT;
      end
      S_WAIT: w_state_next = S_RESP;
      S_RESP: begin
        rsp_valid    = 1'b1;
        rsp_err      = r_err;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request latch and response data; rdata changes only when entering RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_addr  <= w_addr_eff;
            r_wdata <= req_wdata;
            r_err   <= w_err;
            if (w_err) r_rdata <= 32'd0;
          end
        end
        S_ISSUE: if (r_op[3]) r_rdata <= 32'd0;
        S_WAIT:  r_rdata <= w_load_data;
        default: r_rdata <= r_rdata;
      endcase
    end
  end

  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_ctl.sv
// Testbench for mem_access_ctl: byte-lane memory model plus a byte-level
// big-endian reference model; directed cases followed by random traffic.
`timescale 1ns/1ps
module tb_mem_access_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wren;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem_words [64];
  logic [7:0]  ref_mem [256];
  int          wr_cycles = 0;
  logic [3:0]  last_wren;
  logic [31:0] last_din;
  logic [31:0] last_waddr;

  always #5 clk = ~clk;

  mem_access_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_addr  (mem_addr),
    .mem_wren  (mem_wren),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Synchronous byte-lane memory, one-cycle read latency
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (mem_wren[l]) mem_words[mem_addr[7:2]][8*l +: 8] <= mem_din[8*l +: 8];
    mem_dout <= mem_words[mem_addr[7:2]];
  end

  // Write monitor
  always @(negedge clk) begin
    if (mem_wren != 4'b0000) begin
      wr_cycles  = wr_cycles + 1;
      last_wren  = mem_wren;
      last_din   = mem_din;
      last_waddr = mem_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: byte-addressed big-endian memory, updated on stores
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output logic st,
                       output logic [3:0] wren, output logic [31:0] din);
    int   size;
    int   off;
    int   base;
    bit   legal;
    bit   mis;
    logic [31:0] v;
    legal = 1'b1;
    size  = 1;
    case (op)
      4'd0, 4'd1, 4'd8: size = 1;
      4'd2, 4'd3, 4'd9: size = 2;
      4'd4, 4'd10:      size = 4;
      default:          legal = 1'b0;
    endcase
    st   = op[3];
    off  = int'(a[1:0]);
    mis  = (off % size) != 0;
    base = int'(a[7:0]) - (off % size);
`ifdef MISALIGN_TRAP_EN
    err = !legal || mis;
`else
    err = !legal;
`endif
    rd   = 32'd0;
    wren = 4'b0000;
    din  = 32'd0;
    if (!err) begin
      if (st) begin
        for (int i = 0; i < size; i++) begin
          ref_mem[8'(base + i)] = 8'(wd >> (8 * (size - 1 - i)));
          wren[2'(3 - ((base + i) % 4))] = 1'b1;
        end
        if (size == 1)      din = {4{wd[7:0]}};
        else if (size == 2) din = {2{wd[15:0]}};
        else                din = wd;
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = (v << 8) | {24'd0, ref_mem[8'(base + i)]};
        if (op == 4'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (op == 4'd2 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd;
    logic        e_st;
    logic [3:0]  e_wren;
    logic [31:0] e_din;
    int n, lat, wr0, e_lat;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    wr0 = wr_cycles;
    model(op, a, wd, e_err, e_rd, e_st, e_wren, e_din);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    e_lat = e_err ? 1 : (e_st ? 2 : 3);
    check_eq("latency", 32'(lat), 32'(e_lat));
    check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
    check_eq("rsp_rdata", rsp_rdata, e_rd);
    check_eq("wr_cycles", 32'(wr_cycles - wr0), (e_st && !e_err) ? 32'd1 : 32'd0);
    if (e_st && !e_err) begin
      check_eq("wren", {28'd0, last_wren}, {28'd0, e_wren});
      check_eq("din", last_din, e_din);
      check_eq("waddr", last_waddr, {a[31:2], 2'b00});
    end
    got = rsp_rdata;
    $display("[TB] op=%h addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             op, a, wd, rsp_err, rsp_rdata, lat);
  endtask

  logic [31:0] got;
  logic [3:0]  legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10};

  initial begin
    int n;
    logic [3:0] op;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    #12;
    check_eq("reset_ready", {31'd0, req_ready}, 32'd1);
    check_eq("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("reset_wren", {28'd0, mem_wren}, 32'd0);
    check_eq("reset_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Initialise every memory word through the DUT
    for (int i = 0; i < 64; i++) do_req(4'd10, 32'(4 * i), $urandom, got);

    // Directed cases
    do_req(4'd10, 32'h10, 32'hA1B2C3D4, got);
    do_req(4'd4,  32'h10, 32'd0, got);
    check_eq("lw_10", got, 32'hA1B2C3D4);
    do_req(4'd8,  32'h13, 32'h000000F0, got);
    check_eq("sb13_wren", {28'd0, last_wren}, 32'h1);
    check_eq("sb13_din", last_din, 32'hF0F0F0F0);
    do_req(4'd0,  32'h13, 32'd0, got);
    check_eq("lb_13", got, 32'hFFFFFFF0);
    do_req(4'd1,  32'h13, 32'd0, got);
    check_eq("lbu_13", got, 32'h000000F0);
    do_req(4'd10, 32'h20, 32'h12345678, got);
    do_req(4'd9,  32'h22, 32'h00008001, got);
    check_eq("sh22_wren", {28'd0, last_wren}, 32'h3);
    do_req(4'd2,  32'h22, 32'd0, got);
    check_eq("lh_22", got, 32'hFFFF8001);
    do_req(4'd3,  32'h22, 32'd0, got);
    check_eq("lhu_22", got, 32'h00008001);
    do_req(4'd2,  32'h20, 32'd0, got);
    check_eq("lh_20", got, 32'h00001234);
    do_req(4'd4,  32'h31, 32'd0, got);

    // Illegal op with req_valid held high: re-accepted only after RESP
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_op    = 4'hF;
    req_addr  = 32'h44;
    @(negedge clk);
    check_eq("ill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("ill_rsp_err", {31'd0, rsp_err}, 32'd1);
    check_eq("ill_ready_busy", {31'd0, req_ready}, 32'd0);
    check_eq("ill_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    check_eq("ill_ready_idle", {31'd0, req_ready}, 32'd1);
    check_eq("ill_rsp_gap", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check_eq("ill_rsp_again", {31'd0, rsp_valid}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("ill_rsp_done", {31'd0, rsp_valid}, 32'd0);
    $display("[TB] op=f addr=00000044 held valid -> two error responses");

    // Store aborted by reset during its ISSUE cycle
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_op    = 4'd10;
    req_addr  = 32'h40;
    req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_pre_wren", {28'd0, mem_wren}, 32'hF);
    #1 rst = 1'b1;
    #1 check_eq("abort_wren", {28'd0, mem_wren}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
    check_eq("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check_eq("abort_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
    $display("[TB] op=a addr=00000040 aborted by reset");
    do_req(4'd4, 32'h40, 32'd0, got);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
      else                          op = 4'($urandom_range(0, 15));
      do_req(op, $urandom, $urandom, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
